multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
// - Multiply/divide unit in the EX stage. Owns the HI/LO registers and models fixed multi-cycle latency.
// - Drives the busy flag that the pipeline hazard controller uses to stall MD-class instructions in ID.
// - Honours the flush disable from that controller, so a flushed EX instruction never touches HI/LO.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles after the start cycle for MULT/MULTU; must be >= 1
// - DIV_CYCLES   10  busy cycles after the start cycle for DIV/DIVU; must be >= 1
// PORTS
// - clk      in   1   rising-edge clock
// - reset    in   1   asynchronous, active-low; 0 = reset
// - md_op    in   3   EX-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
// - op_a     in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
// - op_b     in   32  rt operand (divisor / multiplier)
// - dis      in   1   flush disable; 1 = suppress any op presented this cycle
// - busy     out  1   1 = start accepted this cycle, or an operation is in flight
// - hi       out  32  committed HI
// - lo       out  32  committed LO
// BEHAVIOUR
// - Reset values: hi = 0, lo = 0, busy = 0. The counter and pending results are also cleared.
// - Assertion of reset aborts any in-flight operation with no commit. No result appears after reset releases.
// - Accept condition: md_op in 1..6 AND dis == 0 AND busy_reg == 0.
//   - busy_reg is the registered in-flight state.
//   - When busy_reg == 1, md_op is ignored entirely. ID stalling prevents this case; it is not an error.
// - busy = busy_reg | (accept AND md_op in 1..4). It is combinational, so an MD instruction in ID stalls in the same cycle its predecessor starts.
// - MTHI/MTLO: on accept, hi (or lo) <= op_a at the closing edge. They never set busy.
// - MULT/MULTU on accept:
//   - MULT uses signed 32x32 -> 64; MULTU uses unsigned.
//   - Pending {hi,lo} = product[63:32], product[31:0]. It is computed from the op_a/op_b values at the accept edge.
//   - Counter loads MULT_CYCLES.
// - DIV/DIVU on accept:
//   - Pending lo = quotient, hi = remainder. DIV is signed: quotient truncates toward zero, and the remainder takes the sign of the dividend. DIVU is unsigned.
//   - Counter loads DIV_CYCLES.
//   - Divisor 0: the op still runs the full DIV_CYCLES latency and busy behaves normally, but hi/lo are left unchanged at commit.
//   - DIV 0x80000000 / -1: lo = 0x80000000, hi = 0. No trap.
// - Timeline for a start in cycle T with latency N:
//   - busy_reg = 1 in cycles T+1 .. T+N. The counter decrements each edge.
//   - Pending results commit to hi/lo at the edge closing cycle T+N.
//   - In cycle T+1+N, busy = 0 and hi/lo show the new values.
// - dis == 1 during cycles T+1 .. T+N does NOT abort; that operation belongs to an older, committed instruction.
// - dis == 1 in the start cycle means no accept, no busy, and hi/lo untouched.
// - Operands are captured at accept. Later changes on op_a/op_b have no effect.
// - hi/lo change only at commit or at MTHI/MTLO. Between those events they hold their values.
// TESTING
// - Reset, then MULT with op_a=0xFFFFFFFE (-2), op_b=3 -> busy high in the start cycle plus 5 following cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
// - MULTU with op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> after 6 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
// - DIV with op_a=-7, op_b=2 -> busy for 11 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. A following DIVU by 0 -> 11 busy cycles, and hi/lo stay unchanged.
// - MTHI 0x12345678 with dis=1 -> hi unchanged, busy=0. The same op with dis=0 -> hi=0x12345678 next cycle, busy stays 0.
// - MULT started, then dis=1 pulsed in cycle T+2 -> result still commits at T+5. A second MULT presented while busy is ignored (hi/lo reflect the first op only).
// - Pull reset to 0 mid-DIV at cycle T+4 -> busy=0 and hi=lo=0 immediately; after release there is no late commit.

Source files
------------

// File: rtl/multdiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO and models fixed MULT/DIV latency.
// Results are computed at accept and held as pending state until the countdown ends.
module multdiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        dis,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_NONE7
  } md_op_e;

  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  md_op_e        op;
  logic          busy_reg, accept, is_long;
  logic [CW-1:0] cnt;
  md_res_t       pend;

  assign op      = md_op_e'(md_op);
  assign accept  = (op != OP_NONE) && (op != OP_NONE7) && !dis && !busy_reg;
  assign is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign busy    = busy_reg | (accept & is_long);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  logic        sgn_mul;
  logic [63:0] mul_a, mul_b, prod;
  assign sgn_mul = (op == OP_MULT);
  assign mul_a   = {{32{sgn_mul & op_a[31]}}, op_a};
  assign mul_b   = {{32{sgn_mul & op_b[31]}}, op_b};
  assign prod    = mul_a * mul_b;

  // Signed divide via magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
  logic        sgn_div, a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;
  assign sgn_div = (op == OP_DIV);
  assign a_neg   = sgn_div & op_a[31];
  assign b_neg   = sgn_div & op_b[31];
  assign ua      = a_neg ? -op_a : op_a;
  assign ub      = b_neg ? -op_b : op_b;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign quo     = (a_neg ^ b_neg) ? -uq : uq;
  assign rem     = a_neg ? -ur : ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= 1'b0;
      cnt      <= '0;
      pend     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (busy_reg) begin
      // In flight: md_op is ignored; dis cannot abort an already-started op.
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy_reg <= 1'b0;
        if (pend.we) begin
          hi <= pend.hi;
          lo <= pend.lo;
        end
      end
    end else if (accept) begin
      case (op)
        OP_MTHI: hi <= op_a;
        OP_MTLO: lo <= op_a;
        OP_MULT, OP_MULTU: begin
          busy_reg <= 1'b1;
          cnt      <= CW'(MULT_CYCLES);
          pend     <= '{we: 1'b1, hi: prod[63:32], lo: prod[31:0]};
        end
        OP_DIV, OP_DIVU: begin
          busy_reg <= 1'b1;
          cnt      <= CW'(DIV_CYCLES);
          pend     <= '{we: (op_b != 32'd0), hi: rem, lo: quo};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus queues expected HI/LO per long op,
// a monitor pops and compares whenever busy falls (commit point).
module tb_multdiv_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        dis = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  multdiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .op_a(op_a), .op_b(op_b),
    .dis(dis), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a falling busy marks a commit; compare HI/LO against the oldest expectation.
  logic prev_busy = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) prev_busy = 1'b0;
    else begin
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL unexpected_commit: got hi=%h lo=%h expected no commit", hi, lo);
        end else begin
          e = q.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
        end
      end
      prev_busy = busy;
    end
  end

  // Issue one op for one cycle, scramble operands afterwards, count busy cycles from the start cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d, input int exp_busy, input string nm);
    int n;
    @(posedge clk); #1;
    md_op = op; op_a = a; op_b = b; dis = d;
    #1 n = busy ? 1 : 0;
    @(posedge clk); #1;
    md_op = 3'd0; op_a = ~a; op_b = ~b; dis = 1'b0;
    #1;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #2;
    end
    chk(nm, 32'(n), 32'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, MC + 1, "mult_busy");
    q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MC + 1, "multu_busy");
    q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DC + 1, "div_busy");
    q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    run_op(3'd4, 32'd100, 32'd0, 1'b0, DC + 1, "divu0_busy");
    q.push_back('{hi: 32'h0000_0000, lo: 32'h8000_0000});
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC + 1, "div_ovf_busy");
    q.push_back('{hi: 32'd2, lo: 32'd14});
    run_op(3'd4, 32'd100, 32'd7, 1'b0, DC + 1, "divu_busy");
    q.push_back('{hi: 32'd1, lo: 32'hFFFF_FFFD});
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, DC + 1, "div_negb_busy");

    run_op(3'd5, 32'h1234_5678, 32'd0, 1'b1, 0, "mthi_dis_busy");
    chk("mthi_dis_hi", hi, 32'd1);
    run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0, 0, "mthi_busy");
    chk("mthi_hi", hi, 32'h1234_5678);
    run_op(3'd6, 32'hCAFE_F00D, 32'd0, 1'b0, 0, "mtlo_busy");
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi_hold", hi, 32'h1234_5678);

    // MULT with dis pulsed at T+2 and further MULTs presented while busy.
    q.push_back('{hi: 32'd0, lo: 32'd42});
    @(posedge clk); #1;
    md_op = 3'd1; op_a = 32'd7; op_b = 32'd6; dis = 1'b0;
    #1 n = busy ? 1 : 0;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1;
      md_op = (k <= 3) ? 3'd1 : 3'd0;
      op_a = 32'd100; op_b = 32'd100;
      dis = (k == 2);
      #1;
      if (!busy) break;
      n++;
    end
    md_op = 3'd0; dis = 1'b0;
    chk("mult_dis_busy", 32'(n), 32'(MC + 1));

    // Reset mid-DIV: no expectation queued, so any later commit is flagged by the monitor.
    @(posedge clk); #1;
    md_op = 3'd3; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1 md_op = 3'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (DC + 5) @(posedge clk);
    #2;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
